// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash bridge and controller instances:
// state encoding, flash window base and error read value.
package spi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        WAIT    = ST_WAIT,
        RELEASE = ST_RELEASE,
        ERR     = ST_ERR,
        DRAIN   = ST_DRAIN
    } bridge_state_t;

    localparam logic [7:0]  FLASH_BASE_DEFAULT = 8'h20;
    localparam logic [31:0] ERR_VALUE_DEFAULT  = 32'hDEADBEEF;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/spi_mem_bridge.sv
// Memory-stage to SPI flash bridge: decodes flash-window accesses, issues one
// controller transaction at a time and stalls the pipeline until it completes.
module spi_mem_bridge
    import spi_pkg::*;
#(
    parameter logic [7:0]  FLASH_BASE     = FLASH_BASE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_VALUE      = ERR_VALUE_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Stall,
    output logic        BusErr,
    output logic        spi_start,
    output logic        spi_we,
    output logic [31:0] spi_addr,
    output logic [31:0] spi_wdata,
    input  logic [31:0] spi_rdata,
    input  logic        spi_data_ready
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    bridge_state_t state;
    bridge_state_t state_next;
    logic [CW-1:0] to_cnt;
    logic          hit;
    logic          misaligned;

    assign hit        = MemReq && (A[31:24] == FLASH_BASE);
    assign misaligned = hit && !word_aligned(A[1:0]);

    // A hit arriving in DRAIN is held off here and decoded once back in IDLE.
    assign Stall     = ((state == IDLE) && hit) || (state == ISSUE) || (state == WAIT)
                       || ((state == DRAIN) && hit);
    assign spi_start = (state == ISSUE);
    assign BusErr    = (state == ERR);

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; completion beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    state_next = ERR;
                end else if (hit) begin
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (spi_data_ready) begin
                    state_next = RELEASE;
                end else if (to_cnt == TO_LAST) begin
                    state_next = ERR;
                end else begin
                    state_next = WAIT;
                end
            end
            RELEASE: state_next = DRAIN;
            ERR:     state_next = DRAIN;
            DRAIN: begin
                if (!spi_data_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, timeout counter and read-data return register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            spi_we    <= 1'b0;
            spi_addr  <= 32'h0000_0000;
            spi_wdata <= 32'h0000_0000;
            to_cnt    <= '0;
            RD        <= 32'h0000_0000;
        end else begin
            if ((state == IDLE) && hit && !misaligned) begin
                spi_we    <= WE;
                spi_addr  <= A;
                spi_wdata <= WD;
            end
            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if ((state == WAIT) && !spi_data_ready && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            // Stores complete without disturbing the last load value.
            if ((state == WAIT) && spi_data_ready && !spi_we) begin
                RD <= spi_rdata;
            end else if (state_next == ERR) begin
                RD <= ERR_VALUE;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboard bench for spi_mem_bridge with a behavioural SPI controller model
// (data_ready a set number of cycles after start, then held for a set count).
module tb_spi_mem_bridge;

    localparam int TO = 64;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        MemReq = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] WD = 32'h0;
    logic [31:0] RD;
    logic        Stall;
    logic        BusErr;
    logic        spi_start;
    logic        spi_we;
    logic [31:0] spi_addr;
    logic [31:0] spi_wdata;
    logic [31:0] spi_rdata;
    logic        spi_data_ready;

    spi_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .reset(reset), .MemReq(MemReq), .WE(WE), .A(A), .WD(WD),
        .RD(RD), .Stall(Stall), .BusErr(BusErr), .spi_start(spi_start),
        .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_rdata(spi_rdata), .spi_data_ready(spi_data_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
        int          stall;
        int          starts;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   total_starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller model
    int          ctrl_lat = 0;
    int          ctrl_hold = 3;
    logic [31:0] ctrl_rdata = 32'h0;
    int          mcnt = 0;
    int          mhold = 0;
    assign spi_rdata = ctrl_rdata;

    always @(posedge CLK) begin
        if (reset) begin
            mcnt <= 0;
            mhold <= 0;
            spi_data_ready <= 1'b0;
        end else begin
            if (spi_start && ctrl_lat >= 2) mcnt <= ctrl_lat - 1;
            else if (mcnt > 1) mcnt <= mcnt - 1;
            else if (mcnt == 1) begin
                mcnt <= 0;
                spi_data_ready <= 1'b1;
                mhold <= ctrl_hold;
            end
            if (mhold > 1) mhold <= mhold - 1;
            else if (mhold == 1) begin
                mhold <= 0;
                spi_data_ready <= 1'b0;
            end
        end
    end

    // Monitor: accumulates per-transaction activity, compares on the Stall-low cycle
    int          stall_cnt = 0;
    int          start_cnt = 0;
    int          err_cnt = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    exp_t        e;

    always @(negedge CLK) begin
        if (!reset) begin
            if (spi_start) begin
                start_cnt++;
                total_starts++;
                cap_we = spi_we;
                cap_addr = spi_addr;
                cap_wdata = spi_wdata;
                check("ready_low_at_start", {31'd0, spi_data_ready}, 32'd0);
            end
            if (BusErr) err_cnt++;
            if (MemReq && Stall) begin
                stall_cnt++;
            end else if (MemReq && !Stall && stall_cnt > 0) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_response: RD %h with empty scoreboard", RD);
                end else begin
                    e = sbq.pop_front();
                    check("rd", RD, e.rd);
                    check("buserr_now", {31'd0, BusErr}, {31'd0, e.berr});
                    check("buserr_pulses", err_cnt, e.berr ? 32'd1 : 32'd0);
                    check("stall_cycles", stall_cnt, e.stall);
                    check("start_pulses", start_cnt, e.starts);
                    if (e.starts == 1) begin
                        check("spi_we", {31'd0, cap_we}, {31'd0, e.we});
                        check("spi_addr", cap_addr, e.addr);
                        check("spi_wdata", cap_wdata, e.wdata);
                    end
                end
                stall_cnt = 0;
                start_cnt = 0;
                err_cnt = 0;
            end
        end
    end

    // Present one access (called at posedge+1) and hold it until Stall drops.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input exp_t ex);
        bit done = 1'b0;
        sbq.push_back(ex);
        MemReq = 1'b1;
        WE = we;
        A = a;
        WD = wd;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (!Stall) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL stall_bound: Stall still high after 300 cycles, required low");
        end
        @(posedge CLK);
        #1;
        MemReq = 1'b0;
        WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_RD"}, RD, 32'h0);
        check({tag, "_Stall"}, {31'd0, Stall}, 32'd0);
        check({tag, "_BusErr"}, {31'd0, BusErr}, 32'd0);
        check({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
        check({tag, "_spi_we"}, {31'd0, spi_we}, 32'd0);
        check({tag, "_spi_addr"}, spi_addr, 32'h0);
        check({tag, "_spi_wdata"}, spi_wdata, 32'h0);
    endtask

    initial begin
        int st0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset");
        @(posedge CLK);
        #1;
        reset = 1'b0;
        idle(2);

        // 1: load, controller ready 40 cycles after start
        ctrl_lat = 40; ctrl_hold = 3; ctrl_rdata = 32'hCAFEF00D;
        xfer(1'b0, 32'h2000_0010, 32'h0,
             '{rd: 32'hCAFEF00D, berr: 1'b0, stall: 42, starts: 1, we: 1'b0,
               addr: 32'h2000_0010, wdata: 32'h0});
        idle(6);

        // 2: store leaves RD untouched
        ctrl_lat = 5; ctrl_rdata = 32'h5555_5555;
        xfer(1'b1, 32'h2000_0100, 32'h1234_5678,
             '{rd: 32'hCAFEF00D, berr: 1'b0, stall: 7, starts: 1, we: 1'b1,
               addr: 32'h2000_0100, wdata: 32'h1234_5678});
        idle(6);

        // 3: misses never stall and never start
        st0 = total_starts;
        MemReq = 1'b1; A = 32'h1000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("miss_stall", {31'd0, Stall}, 32'd0);
        end
        @(posedge CLK);
        #1;
        MemReq = 1'b0;
        check("miss_starts", total_starts - st0, 32'd0);
        idle(2);

        // 4: controller never responds -> timeout
        ctrl_lat = 0;
        xfer(1'b0, 32'h2000_0200, 32'h0,
             '{rd: 32'hDEADBEEF, berr: 1'b1, stall: TO + 2, starts: 1, we: 1'b0,
               addr: 32'h2000_0200, wdata: 32'h0});
        idle(4);

        // 5: misaligned flash access errors without touching the controller
        xfer(1'b0, 32'h2000_0002, 32'h0,
             '{rd: 32'hDEADBEEF, berr: 1'b1, stall: 1, starts: 0, we: 1'b0,
               addr: 32'h0, wdata: 32'h0});
        idle(4);

        // 6: back-to-back loads, ready held 8 cycles; second waits in DRAIN
        ctrl_lat = 10; ctrl_hold = 8; ctrl_rdata = 32'h1111_2222;
        xfer(1'b0, 32'h2000_0020, 32'h0,
             '{rd: 32'h1111_2222, berr: 1'b0, stall: 12, starts: 1, we: 1'b0,
               addr: 32'h2000_0020, wdata: 32'h0});
        ctrl_rdata = 32'h3333_4444;
        xfer(1'b0, 32'h2000_0024, 32'h0,
             '{rd: 32'h3333_4444, berr: 1'b0, stall: 19, starts: 1, we: 1'b0,
               addr: 32'h2000_0024, wdata: 32'h0});
        idle(12);

        // Reset while in WAIT abandons the transaction
        ctrl_lat = 0;
        MemReq = 1'b1; WE = 1'b0; A = 32'h2000_0040;
        repeat (10) @(negedge CLK);
        check("wait_stall", {31'd0, Stall}, 32'd1);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        MemReq = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_zero("midreset");
        @(posedge CLK);
        #1;
        reset = 1'b0;
        idle(3);

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
